// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: E-stage operand forwarding,
// load-use / branch / mul-div stall and flush generation, and stall/flush cycle counters.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    input  logic             md_done,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             md_start,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t       state_reg;
    md_state_t       state_next;
    logic            md_stall;
    logic            md_start_next;
    logic            lw_stall;
    logic [1:0][4:0] rs_e;

    assign rs_e = {Rs2E, Rs1E};

    // One forwarding mux per E-stage source operand; the M stage holds the newer value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [1:0] fwd;
            always_comb begin
                fwd = 2'b00;
                if (rs_e[gi] != 5'd0 && rs_e[gi] == RdM && RegWriteM) begin
                    fwd = 2'b10;
                end else if (rs_e[gi] != 5'd0 && rs_e[gi] == RdW && RegWriteW) begin
                    fwd = 2'b01;
                end
            end
        end
    endgenerate

    assign ForwardAE = g_fwd[0].fwd;
    assign ForwardBE = g_fwd[1].fwd;

    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The md_done cycle itself is not stalled, so E advances on that edge.
    always_comb begin
        state_next    = state_reg;
        md_stall      = 1'b0;
        md_start_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MulDivE) begin
                    md_start_next = 1'b1;
                    md_stall      = 1'b1;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_next = IDLE;
                end else begin
                    md_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        md_start = 1'b0;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        if (!reset) begin
            md_start = md_start_next;
            StallF   = lw_stall | md_stall;
            StallD   = lw_stall | md_stall;
            StallE   = md_stall;
            FlushM   = md_stall;
            FlushE   = !md_stall && (lw_stall || PCSrcE);
            FlushD   = !md_stall && PCSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (StallF && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (FlushE && (flush_cycles != '1)) begin
                flush_cycles <= flush_cycles + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // A redirect cannot resolve in E while E is frozen behind a mul/div op.
    a_no_branch_in_busy : assert property (@(posedge clk) disable iff (reset)
        !(state_reg == BUSY && PCSrcE));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, mul/div handshake,
// reset while busy, and counter saturation on a narrow-counter instance.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE, md_done;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, md_start;
    logic [31:0] stall_cycles, flush_cycles;

    logic [1:0]  ForwardAE4, ForwardBE4;
    logic        StallF4, StallD4, StallE4, FlushD4, FlushE4, FlushM4, md_start4;
    logic [3:0]  stall_cycles4, flush_cycles4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .MulDivE(MulDivE), .md_done(md_done),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .md_start(md_start), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .MulDivE(MulDivE), .md_done(md_done),
        .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
        .StallF(StallF4), .StallD(StallD4), .StallE(StallE4),
        .FlushD(FlushD4), .FlushE(FlushE4), .FlushM(FlushM4),
        .md_start(md_start4), .stall_cycles(stall_cycles4), .flush_cycles(flush_cycles4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
        PCSrcE = 1'b0; MulDivE = 1'b0; md_done = 1'b0;
    endtask

    // Packs the six pipeline controls as {StallF,StallD,StallE,FlushD,FlushE,FlushM}.
    function automatic logic [31:0] ctl();
        return 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM});
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        // Controls forced low during reset; forwarding still live.
        MulDivE = 1'b1; PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
        #1;
        check("rst_ctl", ctl(), 32'd0);
        check("rst_md_start", 32'(md_start), 32'd0);
        check("rst_fwdA", 32'(ForwardAE), 32'd2);
        tick();
        check("rst_stall_cnt", stall_cycles, 32'd0);
        check("rst_flush_cnt", flush_cycles, 32'd0);
        clear_inputs();
        reset = 1'b0;
        #1;
        check("idle_ctl", ctl(), 32'd0);

        // Forwarding priority and x0
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
        #1; check("fwdA_m_wins", 32'(ForwardAE), 32'd2);
        RegWriteM = 1'b0;
        #1; check("fwdA_w", 32'(ForwardAE), 32'd1);
        Rs1E = 5'd0; RdW = 5'd0;
        #1; check("fwdA_x0", 32'(ForwardAE), 32'd0);
        RdM = 5'd3; RegWriteM = 1'b1; Rs2E = 5'd3;
        #1; check("fwdB_m", 32'(ForwardBE), 32'd2);
        Rs2E = 5'd9;
        #1; check("fwdB_none", 32'(ForwardBE), 32'd0);
        clear_inputs();

        // Load-use on Rs2D; x0 destination never stalls
        ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        #1; check("lw_x0_ctl", ctl(), 32'd0);
        RdE = 5'd7; Rs1D = 5'd1; Rs2D = 5'd7;
        #1; check("lw_ctl", ctl(), 32'b110010);
        tick();
        ResultSrcE0 = 1'b0; RdE = 5'd0;
        #1;
        check("lw_released", ctl(), 32'd0);
        check("lw_stall_cnt", stall_cycles, 32'd1);
        check("lw_flush_cnt", flush_cycles, 32'd1);
        clear_inputs();

        // Taken branch alone, then branch coinciding with load-use
        PCSrcE = 1'b1;
        #1; check("br_ctl", ctl(), 32'b000110);
        tick();
        ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
        #1; check("br_lw_ctl", ctl(), 32'b110110);
        tick();
        clear_inputs();
        #1;
        check("br_stall_cnt", stall_cycles, 32'd2);
        check("br_flush_cnt", flush_cycles, 32'd3);

        // Stray md_done in IDLE is ignored
        md_done = 1'b1;
        #1; check("idle_done_ctl", ctl(), 32'd0);
        tick();
        md_done = 1'b0;

        // Mul/div: start, 3 busy cycles, done on the 4th cycle after start
        MulDivE = 1'b1;
        #1;
        check("md_start_c0", 32'(md_start), 32'd1);
        check("md_ctl_c0", ctl(), 32'b111001);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("md_start_c%0d", i), 32'(md_start), 32'd0);
            check($sformatf("md_ctl_c%0d", i), ctl(), 32'b111001);
        end
        tick();
        md_done = 1'b1;
        #1;
        check("md_done_ctl", ctl(), 32'd0);
        check("md_done_start", 32'(md_start), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("md_stall_cnt", stall_cycles, 32'd6);
        check("md_flush_cnt", flush_cycles, 32'd3);

        // Reset two cycles after md_start abandons the op
        MulDivE = 1'b1;
        #1; check("md2_start", 32'(md_start), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("md2_rst_ctl", ctl(), 32'd0);
        check("md2_rst_start", 32'(md_start), 32'd0);
        tick();
        reset = 1'b0;
        MulDivE = 1'b0;
        #1;
        check("md2_after_rst_ctl", ctl(), 32'd0);
        check("md2_after_rst_cnt", stall_cycles, 32'd0);
        MulDivE = 1'b1;
        #1; check("md3_fresh_start", 32'(md_start), 32'd1);
        tick();
        md_done = 1'b1;
        #1; check("md3_done_ctl", ctl(), 32'd0);
        tick();
        clear_inputs();
        #1; check("md3_stall_cnt", stall_cycles, 32'd1);

        // Counter saturation on the 4-bit instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", 32'(stall_cycles4), 32'd14);
        for (int i = 0; i < 6; i++) tick();
        check("sat_hold", 32'(stall_cycles4), 32'd15);
        check("wide_20", stall_cycles, 32'd20);
        check("sat_flush_hold", 32'(flush_cycles4), 32'd15);
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
